alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU that consumes the 3-bit operation code produced by ALU control
//  and the two register operands. Single-cycle ops (add/sub/and/or/slt) return a
//  registered result one cycle after acceptance. An iterative multiply/divide engine
//  writes HI/LO; it holds in_ready low while busy so the pipeline stalls.
// PARAMETERS
//  W        32   operand/result width; must be >= 4
//  CNT_W    6    iteration counter width; must satisfy 2**CNT_W > W
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  in_valid     in   1      operands/op present this cycle
//  in_ready     out  1      unit can accept; transfer on in_valid&&in_ready at clk edge
//  operation    in   3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  md_op        in   2      00 none (use operation), 01 multu, 10 divu, 11 reserved
//  a, b         in   W      operands (a = rs, b = rt/imm)
//  out_valid    out  1      one-cycle pulse: result/flags valid
//  result       out  W      ALU result; for multu/divu equals new LO
//  zero         out  1      result == 0 (qualified by out_valid)
//  overflow     out  1      signed overflow on add/sub only
//  div_by_zero  out  1      divu with b == 0
//  hi, lo       out  W      HI/LO registers, held between md ops
//  busy         out  1      md engine iterating (== !in_ready)
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=1 (as soon as reset deasserts); out_valid, result, zero,
//   overflow, div_by_zero, hi, lo, busy, counter all 0. Reset mid-op aborts the
//   operation, discards partial products, and never produces out_valid.
//  FSM states: IDLE, MUL, DIV.
//   IDLE: in_ready=1. Accept with md_op=00: result/flags registered at accepting edge,
//    out_valid=1 for the following cycle, stay IDLE (back-to-back accepts allowed, 1/clk).
//    Accept with md_op=01 -> MUL, md_op=10 -> DIV (b!=0); operands latched, cnt=0.
//    Accept with md_op=11 -> treated as md_op=00.
//   MUL: shift-add, one bit/clk, W iterations; in_ready=0, busy=1. On the W-th iteration
//    edge: {hi,lo} = a*b (2W-bit unsigned), result=lo, out_valid pulses next cycle, -> IDLE.
//   DIV: restoring, one quotient bit/clk, W iterations: lo=a/b, hi=a%b (unsigned),
//    result=lo, out_valid pulse, -> IDLE.
//  Latency: md_op=00 out_valid in cycle after accept; multu/divu out_valid exactly W+1
//   edges after accepting edge; in_ready returns to 1 in that same out_valid cycle.
//  divu with b==0: no DIV iterations; at accepting edge hi=a, lo={W{1}}, result=lo,
//   div_by_zero=1, out_valid next cycle (latency 1), stay IDLE.
//  Arithmetic: add/sub modulo 2**W; overflow = sign(a)==sign(b')&&sign(res)!=sign(a),
//   b' = b (add) or ~b+1 (sub); and/or/slt/md ops force overflow=0.
//   slt: result = {W-1 zeros, ($signed(a) < $signed(b))}.
//  Undefined operation codes (011,100,101): result=0, zero=1, out_valid pulses, flags 0.
//  zero/overflow/div_by_zero update only when out_valid pulses; held otherwise.
//  hi/lo modified only by multu/divu; untouched by single-cycle ops.
//  in_valid while in_ready=0 is ignored (upstream holds it); no queueing.
// TESTING
//  1 reset: assert mid-MUL at cycle 5 -> all outputs 0, in_ready=1, no out_valid after.
//  2 add 0x7FFFFFFF+1 -> result 0x80000000, overflow=1; sub 5-5 -> result 0, zero=1.
//  3 slt a=0xFFFFFFFF,b=1 -> result 1; and 0xF0F0&0x0FF0 -> 0x00F0; or -> 0xFFF0.
//  4 multu 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE, out_valid 33 edges after accept, busy=1 between.
//  5 divu 100/7 -> lo=14, hi=2; divu 9/0 -> div_by_zero=1, lo=0xFFFFFFFF, hi=9, latency 1.
//  6 back-to-back add on consecutive cycles -> two consecutive out_valid pulses;
//    in_valid during MUL ignored, hi/lo unchanged by the add that follows.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the pipeline and the execute-stage ALU.
interface alu_exec_unit_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   operation;
  logic [1:0]   md_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;

  modport master (
    output in_valid, operation, md_op, a, b,
    input  in_ready, out_valid, result, zero, overflow, div_by_zero, hi, lo, busy
  );

  modport slave (
    input  in_valid, operation, md_op, a, b,
    output in_ready, out_valid, result, zero, overflow, div_by_zero, hi, lo, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/and/or/slt plus an iterative
// shift-add multiplier and restoring divider that write HI/LO.
module alu_exec_unit #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  alu_exec_unit_if.slave bus
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;
  localparam logic [1:0] MD_MULU = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]     work_q, work_d;    // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [W-1:0]       opnd_q, opnd_d;    // multiplicand or divisor
  logic [W-1:0]       hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic               out_valid_q, out_valid_d, busy_q, busy_d, in_ready_q, in_ready_d;

  logic [W-1:0]       b_eff, add_sum, alu_res;
  logic               alu_ovf;
  logic [W:0]         mul_sum;
  logic [2*W-1:0]     mul_next, div_next;
  logic [W:0]         div_shift;
  logic [W-1:0]       div_diff;
  logic               div_ge;

  // Single-cycle ALU datapath on the incoming operands.
  always_comb begin
    b_eff   = (bus.operation == OP_SUB) ? (~bus.b + W'(1)) : bus.b;
    add_sum = bus.a + b_eff;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.operation)
      OP_ADD, OP_SUB: begin
        alu_res = add_sum;
        alu_ovf = (bus.a[W-1] == b_eff[W-1]) && (add_sum[W-1] != bus.a[W-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  // One iteration step of the multiply and divide engines.
  always_comb begin
    mul_sum   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_next  = {mul_sum, work_q[W-1:1]};
    div_shift = {work_q[2*W-1:W], work_q[W-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[W-1:0] - opnd_q;
    div_next  = {(div_ge ? div_diff : div_shift[W-1:0]), work_q[W-2:0], div_ge};
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.md_op == MD_MULU) begin
            state_d    = MUL;
            cnt_d      = '0;
            work_d     = {{W{1'b0}}, bus.b};
            opnd_d     = bus.a;
            busy_d     = 1'b1;
            in_ready_d = 1'b0;
          end else if (bus.md_op == MD_DIVU && bus.b != '0) begin
            state_d    = DIV;
            cnt_d      = '0;
            work_d     = {{W{1'b0}}, bus.a};
            opnd_d     = bus.b;
            busy_d     = 1'b1;
            in_ready_d = 1'b0;
          end else if (bus.md_op == MD_DIVU) begin
            hi_d        = bus.a;
            lo_d        = '1;
            result_d    = '1;
            zero_d      = 1'b0;
            ovf_d       = 1'b0;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (cnt_q == CNT_W'(W)) begin
          hi_d        = work_q[2*W-1:W];
          lo_d        = work_q[W-1:0];
          result_d    = work_q[W-1:0];
          zero_d      = (work_q[W-1:0] == '0);
          ovf_d       = 1'b0;
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          work_d = (state_q == MUL) ? mul_next : div_next;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight md operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops plus
// hand-written multu/divu, back-to-back and reset-abort sequences.
module tb_alu_exec_unit;
  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  alu_exec_unit_if #(.W(W)) bus();

  alu_exec_unit #(.W(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs [11];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] md,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid  = v;
    bus.operation = op;
    bus.md_op     = md;
    bus.a         = a;
    bus.b         = b;
  endtask

  // Issue an md op, hold a junk add request while busy, measure edges to out_valid.
  task automatic run_md(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_bad);
    drive(1'b1, 3'b010, md, a, b);
    step();
    drive(1'b1, 3'b010, 2'b00, 32'h1, 32'h1);
    lat      = 0;
    busy_bad = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) busy_bad++;
      step();
      if (k >= 30) bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) lat = k;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int bb;
    int seen;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{3'b010, 2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{3'b110, 2'b00, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{3'b111, 2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 2'b00, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 2'b00, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 2'b00, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 2'b00, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[7]  = '{3'b111, 2'b00, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{3'b100, 2'b00, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{3'b010, 2'b11, 32'h00000002, 32'h00000002, 32'h00000004, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 2'b00, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};

    // Reset state
    reset = 1'b1;
    drive(1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Single-cycle vector table
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].md, vecs[i].a, vecs[i].b);
      step();
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'h1);
      check($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(bus.zero), 32'(vecs[i].z));
      check($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].ov));
      check($sformatf("vec%0d_hi", i), bus.hi, 32'h0);
    end

    // Back-to-back adds give consecutive pulses, then out_valid drops
    step();
    drive(1'b1, 3'b010, 2'b00, 32'd1, 32'd2);
    step();
    drive(1'b1, 3'b010, 2'b00, 32'd10, 32'd20);
    check("b2b_ov1", 32'(bus.out_valid), 32'h1);
    check("b2b_res1", bus.result, 32'd3);
    step();
    bus.in_valid = 1'b0;
    check("b2b_ov2", 32'(bus.out_valid), 32'h1);
    check("b2b_res2", bus.result, 32'd30);
    step();
    check("b2b_ov_low", 32'(bus.out_valid), 32'h0);

    // multu 0xFFFFFFFF * 2
    run_md(2'b01, 32'hFFFFFFFF, 32'h2, lat, bb);
    check("mul1_latency", 32'(lat), 32'd33);
    check("mul1_busy_between", 32'(bb), 32'h0);
    check("mul1_hi", bus.hi, 32'h1);
    check("mul1_lo", bus.lo, 32'hFFFFFFFE);
    check("mul1_result", bus.result, 32'hFFFFFFFE);
    check("mul1_in_ready", 32'(bus.in_ready), 32'h1);
    check("mul1_busy", 32'(bus.busy), 32'h0);
    check("mul1_overflow", 32'(bus.overflow), 32'h0);
    step();
    check("mul1_ov_low", 32'(bus.out_valid), 32'h0);
    drive(1'b1, 3'b010, 2'b00, 32'd1, 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("post_mul_add_res", bus.result, 32'd2);
    check("post_mul_add_hi", bus.hi, 32'h1);
    check("post_mul_add_lo", bus.lo, 32'hFFFFFFFE);

    // multu 0x10000 * 0x10000 -> lo=0, zero=1
    run_md(2'b01, 32'h00010000, 32'h00010000, lat, bb);
    check("mul2_latency", 32'(lat), 32'd33);
    check("mul2_hi", bus.hi, 32'h1);
    check("mul2_lo", bus.lo, 32'h0);
    check("mul2_zero", 32'(bus.zero), 32'h1);

    // divu 100 / 7
    run_md(2'b10, 32'd100, 32'd7, lat, bb);
    check("div1_latency", 32'(lat), 32'd33);
    check("div1_busy_between", 32'(bb), 32'h0);
    check("div1_lo", bus.lo, 32'd14);
    check("div1_hi", bus.hi, 32'd2);
    check("div1_result", bus.result, 32'd14);
    check("div1_dbz", 32'(bus.div_by_zero), 32'h0);

    // divu 9 / 0 completes with latency 1
    step();
    drive(1'b1, 3'b010, 2'b10, 32'd9, 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("div0_out_valid", 32'(bus.out_valid), 32'h1);
    check("div0_dbz", 32'(bus.div_by_zero), 32'h1);
    check("div0_lo", bus.lo, 32'hFFFFFFFF);
    check("div0_hi", bus.hi, 32'd9);
    check("div0_result", bus.result, 32'hFFFFFFFF);
    check("div0_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    check("div0_ov_low", 32'(bus.out_valid), 32'h0);
    check("div0_dbz_held", 32'(bus.div_by_zero), 32'h1);
    drive(1'b1, 3'b010, 2'b00, 32'd2, 32'd3);
    step();
    bus.in_valid = 1'b0;
    check("post_div0_dbz", 32'(bus.div_by_zero), 32'h0);
    check("post_div0_res", bus.result, 32'd5);
    check("post_div0_hi", bus.hi, 32'd9);

    // divu boundary cases
    run_md(2'b10, 32'hFFFFFFFF, 32'd1, lat, bb);
    check("div2_lo", bus.lo, 32'hFFFFFFFF);
    check("div2_hi", bus.hi, 32'h0);
    run_md(2'b10, 32'd5, 32'd7, lat, bb);
    check("div3_lo", bus.lo, 32'h0);
    check("div3_hi", bus.hi, 32'd5);
    check("div3_zero", 32'(bus.zero), 32'h1);

    // Reset during MUL aborts it
    step();
    drive(1'b1, 3'b010, 2'b01, 32'd3, 32'd5);
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_out_valid", 32'(bus.out_valid), 32'h0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    check("abort_result", bus.result, 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'h1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    check("abort_no_out_valid", 32'(seen), 32'h0);
    drive(1'b1, 3'b010, 2'b00, 32'd6, 32'd7);
    step();
    bus.in_valid = 1'b0;
    check("abort_then_add", bus.result, 32'd13);
    check("abort_then_add_hi", bus.hi, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
